// File: rtl/ip_ram_arbiter_pkg.sv
// Shared encodings for the two-port RAM arbiter: FSM states, port ids,
// access kinds and the round-robin selection helper.
package ip_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    typedef enum logic {
        KIND_RD = 1'b0,
        KIND_WR = 1'b1
    } kind_t;

    // Pick the port to serve: the only requester, or under contention the
    // port that did not win the previous contention.
    function automatic port_t rr_pick(input logic pend_a, input logic pend_b,
                                      input port_t last_grant);
        if (pend_a && pend_b) begin
            return (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (pend_a) begin
            return PORT_A;
        end else begin
            return PORT_B;
        end
    endfunction

endpackage

// File: rtl/ip_ram_arb_port.sv
// Per-client request latch: captures one rd/wr pulse with its address and
// data, holds it as pending until the arbiter clears it, and drops any
// pulse that arrives while a request is already pending.
module ip_ram_arb_port
    import ip_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              clear,
    output logic              pending,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    output logic              kind
);

    logic take;

    // A new pulse is accepted only when nothing is pending; a pulse on the
    // clearing edge is still seen with pending high and so is dropped.
    assign take = !pending && (req_rd || req_wr);

    // Pending flag and access kind; the flag only falls on an explicit clear.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pending <= 1'b0;
            kind    <= KIND_RD;
        end else if (pending) begin
            if (clear) begin
                pending <= 1'b0;
            end
        end else if (take) begin
            pending <= 1'b1;
            kind    <= req_rd ? KIND_RD : KIND_WR;
        end
    end

    // Captured address/data, only meaningful while pending is high.
    always_ff @(posedge clk) begin
        if (take) begin
            address <= req_address;
            wdata   <= req_wdata;
        end
    end

endmodule

// File: rtl/ip_ram_arbiter.sv
// Shares one RAM controller interface between two clients. Each client's
// pulse is latched, one access is issued at a time with round-robin
// fairness under contention, and read data is routed to the owner only.
module ip_ram_arbiter
    import ip_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              a_rd,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_busy,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rdata_en,
    input  logic              b_rd,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_busy,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rdata_en,
    output logic              rd,
    output logic              wr,
    input  logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rdata_en
);

    state_t            state, next_state;
    port_t             owner, last_grant, grant_port;
    logic              grant;
    logic              pend_a, pend_b, clear_a, clear_b;
    logic              kind_a, kind_b, owner_kind, grant_kind;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              resp;

    ip_ram_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_a (
        .clk(clk), .n_reset(n_reset),
        .req_rd(a_rd), .req_wr(a_wr), .req_address(a_address), .req_wdata(a_wdata),
        .clear(clear_a), .pending(pend_a), .address(addr_a), .wdata(wdata_a), .kind(kind_a)
    );

    ip_ram_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_b (
        .clk(clk), .n_reset(n_reset),
        .req_rd(b_rd), .req_wr(b_wr), .req_address(b_address), .req_wdata(b_wdata),
        .clear(clear_b), .pending(pend_b), .address(addr_b), .wdata(wdata_b), .kind(kind_b)
    );

    assign a_busy     = pend_a;
    assign b_busy     = pend_b;
    assign owner_kind = (owner == PORT_A) ? kind_a : kind_b;
    assign grant_kind = (grant_port == PORT_A) ? kind_a : kind_b;

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, grant decision and pending clears for the owning port.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_port = PORT_A;
        clear_a    = 1'b0;
        clear_b    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!busy && (pend_a || pend_b)) begin
                    grant      = 1'b1;
                    grant_port = rr_pick(pend_a, pend_b, last_grant);
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (owner_kind == KIND_WR) begin
                    clear_a    = (owner == PORT_A);
                    clear_b    = (owner == PORT_B);
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (rdata_en) begin
                    clear_a    = (owner == PORT_A);
                    clear_b    = (owner == PORT_B);
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // RAM-side strobes and address/data; strobes last exactly the ISSUE
    // cycle, address/data hold until the next grant.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd         <= 1'b0;
            wr         <= 1'b0;
            address    <= '0;
            wdata      <= '0;
            owner      <= PORT_A;
            last_grant <= PORT_B;
        end else begin
            rd <= 1'b0;
            wr <= 1'b0;
            if (grant) begin
                owner   <= grant_port;
                address <= (grant_port == PORT_A) ? addr_a : addr_b;
                wdata   <= (grant_port == PORT_A) ? wdata_a : wdata_b;
                rd      <= (grant_kind == KIND_RD);
                wr      <= (grant_kind == KIND_WR);
                if (pend_a && pend_b) begin
                    last_grant <= grant_port;
                end
            end
        end
    end

    // Read data is forwarded only to the owner, and only while waiting for it.
    assign resp       = (state == ST_WAIT_RD) && rdata_en;
    assign a_rdata_en = resp && (owner == PORT_A);
    assign b_rdata_en = resp && (owner == PORT_B);
    assign a_rdata    = a_rdata_en ? rdata : '0;
    assign b_rdata    = b_rdata_en ? rdata : '0;

endmodule

// File: tb/tb_ip_ram_arbiter.sv
// Bench for ip_ram_arbiter: directed scenarios followed by random traffic,
// with a transaction-level reference model feeding a scoreboard.
module tb_ip_ram_arbiter;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic              a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic [ADDR_W-1:0] a_address = '0, b_address = '0;
    logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
    logic              a_busy, b_busy, a_rdata_en, b_rdata_en;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              rd, wr;
    logic              busy = 1'b0;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_en;

    ip_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .n_reset(n_reset),
        .a_rd(a_rd), .a_wr(a_wr), .a_address(a_address), .a_wdata(a_wdata),
        .a_busy(a_busy), .a_rdata(a_rdata), .a_rdata_en(a_rdata_en),
        .b_rd(b_rd), .b_wr(b_wr), .b_address(b_address), .b_wdata(b_wdata),
        .b_busy(b_busy), .b_rdata(b_rdata), .b_rdata_en(b_rdata_en),
        .rd(rd), .wr(wr), .busy(busy), .address(address), .wdata(wdata),
        .rdata(rdata), .rdata_en(rdata_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- RAM controller responder ----------------
    int               lat = 3;
    bit               lat_rand = 1'b0;
    bit               force_en = 1'b0;
    logic [7:0]       force_data = 8'h00;
    logic             stray_en = 1'b0;
    int               resp_cnt = 0;
    logic [7:0]       resp_data = 8'h00;
    logic             resp_en = 1'b0;
    logic [7:0]       resp_rdata = 8'h00;

    assign rdata_en = resp_en | stray_en;
    assign rdata    = stray_en ? 8'h77 : resp_rdata;

    always @(posedge clk) begin
        #1;
        resp_en    = 1'b0;
        resp_rdata = 8'($urandom);
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                resp_en    = 1'b1;
                resp_rdata = resp_data;
            end
        end
        if (rd === 1'b1) begin
            resp_cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat;
            resp_data = force_en ? force_data : 8'($urandom);
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        is_rd;
        logic [21:0] addr;
        logic [7:0]  data;
        int          when;
    } strobe_t;

    typedef struct {
        logic [1:0] bsy;
        logic [1:0] en;
        logic [7:0] ard;
        logic [7:0] brd;
    } stat_t;

    strobe_t strobe_q[$];
    stat_t   stat_q[$];

    bit          m_pend[2];
    bit          m_is_rd[2];
    logic [21:0] m_addr[2];
    logic [7:0]  m_data[2];
    bit          m_active = 1'b0;
    int          m_owner = 0;
    int          m_scyc = 0;
    int          m_last = 1;

    // Evaluated mid-cycle: publishes what the DUT should show this cycle,
    // then advances the model across the coming clock edge.
    always @(negedge clk) begin
        stat_t   s;
        strobe_t st;
        bit      resp, done, was_active, pick_b;
        bit      pb[2];
        bit      rq_rd[2], rq_wr[2];
        logic [21:0] rq_addr[2];
        logic [7:0]  rq_data[2];
        if (!n_reset) begin
            m_pend[0] = 0; m_pend[1] = 0;
            m_active = 0; m_last = 1; m_owner = 0;
            s.bsy = 2'b00; s.en = 2'b00; s.ard = 8'h00; s.brd = 8'h00;
            stat_q.push_back(s);
        end else begin
            resp  = m_active && m_is_rd[m_owner] && (cyc > m_scyc) && (rdata_en === 1'b1);
            s.bsy = {m_pend[1], m_pend[0]};
            s.en  = {resp && (m_owner == 1), resp && (m_owner == 0)};
            s.ard = s.en[0] ? rdata : 8'h00;
            s.brd = s.en[1] ? rdata : 8'h00;
            stat_q.push_back(s);

            rq_rd[0] = a_rd; rq_wr[0] = a_wr; rq_addr[0] = a_address; rq_data[0] = a_wdata;
            rq_rd[1] = b_rd; rq_wr[1] = b_wr; rq_addr[1] = b_address; rq_data[1] = b_wdata;
            pb = m_pend;
            was_active = m_active;
            done = m_active && ((!m_is_rd[m_owner] && cyc == m_scyc) || resp);
            if (done) begin
                m_pend[m_owner] = 0;
                m_active = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pb[p] && (rq_rd[p] || rq_wr[p])) begin
                    m_pend[p]  = 1;
                    m_is_rd[p] = rq_rd[p];
                    m_addr[p]  = rq_addr[p];
                    m_data[p]  = rq_data[p];
                end
            end
            if (!was_active && !busy && (pb[0] || pb[1])) begin
                if (pb[0] && pb[1]) begin
                    pick_b = (m_last == 0);
                    m_last = pick_b ? 1 : 0;
                end else begin
                    pick_b = pb[1];
                end
                m_owner  = pick_b ? 1 : 0;
                m_active = 1;
                m_scyc   = cyc + 1;
                st.is_rd = m_is_rd[m_owner];
                st.addr  = m_addr[m_owner];
                st.data  = m_data[m_owner];
                st.when  = m_scyc;
                strobe_q.push_back(st);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        stat_t   s;
        strobe_t st;
        #1;
        if (stat_q.size() == 0) begin
            check("status_queue_empty", 64'(stat_q.size()), 64'd1);
        end else begin
            s = stat_q.pop_front();
            check("port_status", 64'({b_busy, a_busy, b_rdata_en, a_rdata_en, a_rdata, b_rdata}),
                  64'({s.bsy, s.en, s.ard, s.brd}));
        end
        if (rd === 1'b1 || wr === 1'b1) begin
            if (strobe_q.size() == 0) begin
                check("unexpected_strobe", 64'({rd, wr, address}), 64'd0);
            end else begin
                st = strobe_q.pop_front();
                check("strobe", {rd, wr, address, wdata, 32'(cyc)},
                      {st.is_rd, ~st.is_rd, st.addr, st.data, 32'(st.when)});
            end
        end else if (strobe_q.size() > 0 && strobe_q[0].when < cyc) begin
            st = strobe_q.pop_front();
            check("missing_strobe", 64'(cyc), 64'(st.when));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
    endtask

    initial begin
        // reset
        repeat (3) step();
        check("reset_state", 64'({a_busy, b_busy, a_rdata_en, b_rdata_en, a_rdata, b_rdata,
                                  rd, wr, address, wdata}), 64'd0);
        n_reset = 1;
        repeat (2) step();

        // single write from A
        a_wr = 1; a_address = 22'h012345; a_wdata = 8'h5A;
        step(); clear_pulses();
        repeat (6) step();

        // read from B, data returned 3 cycles after rd
        lat = 3; force_en = 1; force_data = 8'hA7;
        b_rd = 1; b_address = 22'h3FC000;
        step(); clear_pulses();
        repeat (10) step();
        force_en = 0;

        // simultaneous requests, twice, to see round-robin alternate
        lat = 2;
        for (int k = 0; k < 2; k++) begin
            a_rd = 1; a_address = 22'h000100 + 22'(k);
            b_wr = 1; b_address = 22'h200200 + 22'(k); b_wdata = 8'hC3 + 8'(k);
            step(); clear_pulses();
            repeat (12) step();
        end

        // RAM busy for 10 cycles while a write is pending
        busy = 1; a_wr = 1; a_address = 22'h0ABCDE; a_wdata = 8'h3C;
        step(); clear_pulses();
        repeat (9) step();
        busy = 0;
        repeat (6) step();

        // second pulse while pending is dropped; stray rdata_en in idle
        lat = 5;
        a_rd = 1; a_address = 22'h111111;
        step(); clear_pulses();
        step();
        a_wr = 1; a_address = 22'h222222; a_wdata = 8'hEE;
        step(); clear_pulses();
        repeat (12) step();
        stray_en = 1;
        step();
        stray_en = 0;
        repeat (3) step();

        // reset during a read wait; the late rdata_en must be ignored
        lat = 6;
        a_rd = 1; a_address = 22'h155555;
        step(); clear_pulses();
        step();
        step();
        @(posedge clk);
        #3;
        n_reset = 0;
        #1;
        check("async_reset_outputs", 64'({a_busy, b_busy, a_rdata_en, b_rdata_en, a_rdata, b_rdata,
                                          rd, wr, address, wdata}), 64'd0);
        @(posedge clk);
        #1;
        n_reset = 1;
        repeat (8) step();
        lat = 2;
        a_rd = 1; a_address = 22'h0F0F0F;
        step(); clear_pulses();
        repeat (8) step();

        // random traffic
        lat_rand = 1;
        for (int i = 0; i < 400; i++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 7));
            rb = int'($urandom_range(0, 7));
            a_rd = (ra == 0) || (ra == 2);
            a_wr = (ra == 1) || (ra == 2);
            b_rd = (rb == 0) || (rb == 2);
            b_wr = (rb == 1) || (rb == 2);
            a_address = 22'($urandom); a_wdata = 8'($urandom);
            b_address = 22'($urandom); b_wdata = 8'($urandom);
            busy = ($urandom_range(0, 4) == 0);
            step();
        end
        clear_pulses();
        busy = 0;
        repeat (20) step();

        check("strobe_queue_drained", 64'(strobe_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
